// File: rtl/turbo_rep_decoder.sv
// Repetition-code frame decoder: loads 4x21-bit beats, majority-votes 5 message bits (ITERATE copies each).
// Latency: done_o 3+ITERATE edges after the beat-0 edge (variable when DECODER_EARLY_STOP_EN is defined).
// Backpressure: none; start_i low mid-load aborts the frame, start_i is ignored while accumulating.
module turbo_rep_decoder #(
    parameter int ITERATE = 16
) (
    input  logic        clk_p_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic [20:0] data_i,
    output logic [4:0]  data_o,
    output logic        done_o
);

    localparam int             FW     = 5 * ITERATE;
    localparam int             J_W    = (ITERATE > 1) ? $clog2(ITERATE) : 1;
    localparam logic [4:0]     HALF   = 5'(ITERATE / 2);
    localparam logic [J_W-1:0] J_LAST = J_W'(ITERATE - 1);
    localparam bit             EVEN   = (ITERATE % 2) == 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [4:0][4:0]   cnt_q, cnt_d;
    logic [4:0]        data_q, data_d;
    logic              done_q, done_d;

    logic [1:0]              beat_slot;
    logic [FW-1:0]           frame_beat;
    logic [4:0][ITERATE-1:0] copies;
    logic [4:0]              cur_bit;
    logic [4:0][4:0]         cnt_sum;
    logic [4:0]              vote;
    logic                    finish;

    // Only the 5*ITERATE payload bits are stored; reserved frame bits never reach a register.
    always_comb begin
        beat_slot  = (state_q == LOAD) ? beat_q : 2'd0;
        frame_beat = frame_q;
        for (int p = 0; p < FW; p++) begin
            if (beat_slot == 2'(3 - p / 21)) begin
                frame_beat[p] = data_i[p % 21];
            end
        end
    end

    always_comb begin
        copies  = '0;
        cur_bit = '0;
        cnt_sum = '0;
        vote    = '0;
        for (int i = 0; i < 5; i++) begin
            copies[i]  = frame_q[ITERATE*i +: ITERATE];
            cur_bit[i] = copies[i][j_q];
            cnt_sum[i] = cnt_q[i] + {4'b0000, cur_bit[i]};
            if (cnt_sum[i] > HALF) begin
                vote[i] = 1'b1;
            end else if (EVEN && (cnt_sum[i] == HALF)) begin
                vote[i] = copies[i][0];
            end else begin
                vote[i] = 1'b0;
            end
        end
    end

`ifdef DECODER_EARLY_STOP_EN
    logic [4:0] settled;

    // A bit is settled once either polarity already holds a strict majority of all copies.
    always_comb begin
        settled = '0;
        for (int i = 0; i < 5; i++) begin
            settled[i] = (cnt_sum[i] > HALF) ||
                         ((5'(j_q) + 5'd1 - cnt_sum[i]) > HALF);
        end
        finish = (j_q == J_LAST) || (&settled);
    end
`else
    always_comb begin
        finish = (j_q == J_LAST);
    end
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        frame_d = frame_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    frame_d = frame_beat;
                    beat_d  = 2'd1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (start_i) begin
                    frame_d = frame_beat;
                    if (beat_q == 2'd3) begin
                        beat_d  = 2'd0;
                        j_d     = '0;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    frame_d = '0;
                    beat_d  = 2'd0;
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                cnt_d = cnt_sum;
                j_d   = j_q + J_W'(1);
                if (finish) begin
                    data_d  = vote;
                    done_d  = 1'b1;
                    j_d     = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_p_i or posedge reset_n_i) begin
        if (reset_n_i) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            frame_q <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            frame_q <= frame_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign data_o = data_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_turbo_rep_decoder.sv
// Directed bench for turbo_rep_decoder (ITERATE=16): decode values, latency, protocol corner cases.
module tb_turbo_rep_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [20:0] din;
    logic [4:0]  dout;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    turbo_rep_decoder #(.ITERATE(16)) dut (
        .clk_p_i   (clk),
        .reset_n_i (rst),
        .start_i   (start),
        .data_i    (din),
        .data_o    (dout),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [83:0] rep(input logic [4:0] m);
        logic [83:0] f;
        f = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 16; j++)
                f[16*i + j] = m[i];
        return f;
    endfunction

    // Leaves the caller at the negedge following the beat-3 capture edge (edge index 3).
    task automatic drive_frame(input logic [83:0] f, input bit now);
        for (int k = 0; k < 4; k++) begin
            if (k > 0 || !now) @(negedge clk);
            start = 1'b1;
            din   = f[83 - 21*k -: 21];
        end
        @(negedge clk);
        start = 1'b0;
        din   = '0;
    endtask

    // Returns at the negedge where done_o is high; lat = index of the edge that raised it.
    task automatic wait_done(input bit toggle, output int lat);
        int n;
        n = 3;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (toggle && n < 11) begin
                start = n[0];
                din   = 21'($urandom);
            end else begin
                start = 1'b0;
                din   = '0;
            end
        end
        lat = n;
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        logic [83:0] f;

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        check("reset_data", {27'b0, dout}, 32'h0);
        check("reset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        drive_frame({4{21'h1FFFFF}}, 0);
        wait_done(0, lat);
`ifdef DECODER_EARLY_STOP_EN
        check("ones_lat", lat, 32'd12);
`else
        check("ones_lat", lat, 32'd19);
`endif
        check("ones_data", {27'b0, dout}, 32'h1F);
        @(negedge clk);
        check("ones_pulse_end", {31'b0, done}, 32'd0);

        drive_frame('0, 0);
        wait_done(0, lat);
`ifndef DECODER_EARLY_STOP_EN
        check("zeros_lat", lat, 32'd19);
`endif
        check("zeros_data", {27'b0, dout}, 32'h00);
        @(negedge clk);
        check("zeros_pulse_end", {31'b0, done}, 32'd0);

        // 3 flipped copies per bit at distinct j, reserved nibble set.
        f = rep(5'b10110);
        for (int i = 0; i < 5; i++) begin
            f[16*i + i]      = ~f[16*i + i];
            f[16*i + i + 5]  = ~f[16*i + i + 5];
            f[16*i + 15 - i] = ~f[16*i + 15 - i];
        end
        f[83:80] = 4'hF;
        drive_frame(f, 0);
        wait_done(0, lat);
        check("flip_data", {27'b0, dout}, 32'h16);

        // Ties: bit2 ones at j=0..7 (copy0=1), bit3 ones at j=8..15 (copy0=0).
        f = '0;
        f[15:0]  = 16'hFFFF;
        f[47:32] = 16'h00FF;
        f[63:48] = 16'hFF00;
        f[79:64] = 16'hFFFF;
        drive_frame(f, 0);
        wait_done(0, lat);
        check("tie_data", {27'b0, dout}, 32'h15);
        check("tie_bit2", {31'b0, dout[2]}, 32'd1);
        @(negedge clk);

        // Abort after two beats.
        f = rep(5'b11111);
        @(negedge clk);
        start = 1'b1; din = f[83:63];
        @(negedge clk);
        din = f[62:42];
        @(negedge clk);
        start = 1'b0; din = '0;
        count_done(25, pulses);
        check("abort_no_done", pulses, 32'd0);
        drive_frame(rep(5'b01001), 0);
        wait_done(0, lat);
`ifndef DECODER_EARLY_STOP_EN
        check("after_abort_lat", lat, 32'd19);
`endif
        check("after_abort_data", {27'b0, dout}, 32'h09);
        @(negedge clk);

        drive_frame(rep(5'b11010), 0);
        wait_done(1, lat);
`ifndef DECODER_EARLY_STOP_EN
        check("toggle_lat", lat, 32'd19);
`endif
        check("toggle_data", {27'b0, dout}, 32'h1A);
        @(negedge clk);

        drive_frame(rep(5'b11111), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_data", {27'b0, dout}, 32'h0);
        check("midreset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(25, pulses);
        check("midreset_no_done", pulses, 32'd0);

        // Back-to-back: next frame starts in the done cycle.
        drive_frame(rep(5'b00111), 0);
        wait_done(0, lat);
        check("b2b_a_data", {27'b0, dout}, 32'h07);
        drive_frame(rep(5'b11100), 1);
        check("b2b_hold", {27'b0, dout}, 32'h07);
        wait_done(0, lat);
`ifdef DECODER_EARLY_STOP_EN
        check("b2b_b_lat", lat, 32'd12);
`else
        check("b2b_b_lat", lat, 32'd19);
`endif
        check("b2b_b_data", {27'b0, dout}, 32'h1C);
        @(negedge clk);
        check("b2b_pulse_end", {31'b0, done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/turbo_rep_decoder.md
Name: turbo_rep_decoder

Overview:
- Frame-level hard-decision decoder for the decode datapath.
- Loads one 84-bit received frame as four consecutive 21-bit beats.
- The frame carries a 5-bit message, with each message bit repeated ITERATE times.
- Accumulates one copy index per cycle, majority-votes each message bit, then presents the 5-bit result with a one-cycle done pulse.

Parameters:
- ITERATE, 16, repetition copies per message bit and accumulation cycles; legal range 1..16, so that 5*ITERATE <= 84.

Ports:
- clk_p_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  reset, asynchronous, active-high (asserted = 1).
- start_i  in  1  beat-valid strobe; must be high for 4 consecutive cycles to load a frame.
- data_i  in  21  frame beat.
- data_o  out  5  decoded message; bit i is message bit i.
- done_o  out  1  one-cycle pulse; data_o is valid in this cycle.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state = IDLE; frame register, copy index and the five counters = 0.
  - data_o = 0, done_o = 0.
- Frame layout, 84 bits:
  - Beat 0 fills frame[83:63], beat 1 fills [62:42], beat 2 fills [41:21], beat 3 fills [20:0].
  - Copy j of message bit i is frame[ITERATE*i + j], for j = 0..ITERATE-1.
  - Bits above 5*ITERATE-1 are reserved and ignored.
- States: IDLE, LOAD, ACCUM.
- IDLE:
  - On a rising edge with start_i=1: capture beat 0, set beat count = 1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Each edge with start_i=1 captures the next beat.
  - On the edge that captures beat 3, go to ACCUM with copy index j = 0 and counters cleared.
  - start_i=0 in LOAD aborts the frame: return to IDLE, discard partial data, no done_o.
- ACCUM:
  - Each edge adds frame[ITERATE*i + j] to 5-bit counter i (for i = 0..4), then increments j.
  - start_i is ignored throughout ACCUM.
- Completion (the edge where j = ITERATE-1):
  - Form the final counts, including that edge's bit.
  - data_o[i] = 1 if count_i > ITERATE/2; data_o[i] = 0 if count_i < ITERATE/2 (integer division).
  - Tie (ITERATE even, count_i == ITERATE/2): data_o[i] = frame[ITERATE*i], i.e. copy 0.
  - Register data_o, drive done_o = 1 for exactly one cycle, return to IDLE.
- Latency: done_o rises on the ITERATE-th rising edge after the edge that captured beat 3, i.e. 3+ITERATE edges after the beat-0 edge (19 for the default).
- data_o holds its value until the next completion or reset; it does not change during later LOAD/ACCUM.
- During the done_o cycle the state is IDLE, so start_i=1 there begins a new frame on the edge that ends the pulse.
- Back-to-back frames are allowed with zero idle cycles.

Optional Feature:
- Macro: DECODER_EARLY_STOP_EN.
- Defined:
  - After each ACCUM edge, check every message bit i.
  - Bit i is settled when count_i > ITERATE/2, or (j+1) - count_i > ITERATE/2.
  - If all five bits are settled, complete on that edge (same data_o/done_o rules), skipping the remaining copies.
  - Latency becomes variable, minimum floor(ITERATE/2)+1 ACCUM edges.
- Undefined: always exactly ITERATE ACCUM edges; fixed latency.
- Decoded data_o values are identical in both builds for every frame.

Test Plan:
- All-ones frame (four beats of 21'h1FFFFF) -> one done_o pulse 19 edges after the first beat, data_o=5'b11111; done_o low the next cycle.
- All-zero frame after a non-zero result -> data_o=5'b00000, done_o single pulse.
- Message 5'b10110 with 3 copies of each bit flipped at various j and reserved bits [83:80]=4'hF -> data_o=5'b10110.
- Tie: bit 2 has 8 ones with copy 0 = 1; bit 3 has 8 ones with copy 0 = 0 -> data_o[2]=1, data_o[3]=0.
- Protocol edge cases:
  - start_i drops after 2 beats -> no done_o; a following clean 4-beat frame decodes correctly.
  - start_i held or toggling during ACCUM -> ignored, result unchanged.
- Reset pulse mid-ACCUM -> data_o=0 and done_o=0 immediately, no done_o afterwards.
- Back-to-back: start_i=1 in the done_o cycle -> next frame's done_o arrives exactly 19 edges after that start edge.
- With DECODER_EARLY_STOP_EN, all-ones frame -> done_o after 9 ACCUM edges, data_o=5'b11111.
